// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer sequencer: state encoding and
// the select-width helper used to size index ports.
package bus_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    LATCH  = 3'd2,
    DONE   = 3'd3,
    REJECT = 3'd4
  } xfer_state_t;

  // Index width for a bank of n registers; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_sel_dec.sv
// Index-to-one-hot decoder for bank control lines; all-zero when valid is
// low or the index is outside the bank.
module bus_sel_dec
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = sel_width(NUM_REGS)
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic                valid,
  output logic [NUM_REGS-1:0] onehot
);

  // Out-of-range indices match no bit, so they can never raise a line.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (valid && (int'(idx) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequencer owning the en/load lines of a shared-bus register bank.
// Optional completed-transfer counter enabled by defining BUS_XFER_COUNT_EN.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = sel_width(NUM_REGS),
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [SEL_W-1:0]    dst_sel,
  output logic                ready,
  output logic [NUM_REGS-1:0] en,
  output logic [NUM_REGS-1:0] load,
  output logic                done,
  output logic                err
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [CNT_W-1:0]    xfer_cnt
`endif
);

  xfer_state_t state, next_state;

  logic [SEL_W-1:0]    src_q, dst_q;
  logic [SEL_W-1:0]    src_d, dst_d;
  logic                req_ok;
  logic                en_valid, load_valid;
  logic [NUM_REGS-1:0] en_d, load_d;

  // Indices are captured only on acceptance, so later sel changes are inert.
  always_comb begin
    next_state = state;
    src_d      = src_q;
    dst_d      = dst_q;
    req_ok     = (src_sel != dst_sel) &&
                 (int'(src_sel) < NUM_REGS) &&
                 (int'(dst_sel) < NUM_REGS);
    case (state)
      IDLE: begin
        if (req) begin
          src_d      = src_sel;
          dst_d      = dst_sel;
          next_state = req_ok ? DRIVE : REJECT;
        end
      end
      DRIVE:   next_state = LATCH;
      LATCH:   next_state = DONE;
      DONE:    next_state = IDLE;
      REJECT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign en_valid   = (next_state == DRIVE) || (next_state == LATCH);
  assign load_valid = (next_state == LATCH);

  bus_sel_dec #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_en_dec (
    .idx    (src_d),
    .valid  (en_valid),
    .onehot (en_d)
  );

  bus_sel_dec #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_load_dec (
    .idx    (dst_d),
    .valid  (load_valid),
    .onehot (load_d)
  );

  // Outputs are decoded from the upcoming state and registered with it, so
  // each control line is glitch-free and aligned with its state cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      ready <= 1'b1;
      en    <= '0;
      load  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      src_q <= src_d;
      dst_q <= dst_d;
      ready <= (next_state == IDLE);
      en    <= en_d;
      load  <= load_d;
      done  <= (next_state == DONE);
      err   <= (next_state == REJECT);
    end
  end

`ifdef BUS_XFER_COUNT_EN
  // Counts on entry to DONE so the new value appears alongside the done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      xfer_cnt <= '0;
    end else if (next_state == DONE) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule
